// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and defaults for the video RAM path
package vga_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 9;
    localparam int SW_DEF = 12;

    // 3:3:3 RGB pixel packing within one RAM word
    localparam int PIX_CH_W  = 3;
    localparam int PIX_B_LSB = 0;
    localparam int PIX_G_LSB = 3;
    localparam int PIX_R_LSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISP_RD = 2'd1,
        ST_HOST_RD = 2'd2,
        ST_HOST_WR = 2'd3
    } issue_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter, display priority over host
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [SW-1:0] host_wait_max
);

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    issue_e        w_next;
    issue_e        r_state;
    issue_e        r_tag;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          w_stall_inc;
    logic          w_stall_clr;
    logic [SW-1:0] w_stall_cnt;
    logic [SW-1:0] r_wait_max;

    // Reset asserts immediately but releases on the clock to avoid partial release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign host_ready = host_valid & ~disp_req;

    always_comb begin
        w_next = ST_IDLE;
        if (disp_req) begin
            w_next = ST_DISP_RD;
        end else if (host_valid) begin
            w_next = host_we ? ST_HOST_WR : ST_HOST_RD;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_tag       <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_tag   <= r_state;
            case (w_next)
                ST_DISP_RD: begin
                    r_mem_en   <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= disp_addr;
                end
                ST_HOST_RD: begin
                    r_mem_en   <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= host_addr;
                end
                ST_HOST_WR: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= host_addr;
                    r_mem_wdata <= host_wdata;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // The tag lags the issue state by the RAM's one-cycle read latency.
    assign disp_rvalid = (r_tag == ST_DISP_RD);
    assign host_rvalid = (r_tag == ST_HOST_RD);
    assign disp_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

    assign w_stall_inc = host_valid & ~host_ready;
    assign w_stall_clr = ~w_stall_inc;

    sat_counter #(.W(SW)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_inc   (w_stall_inc),
        .i_clr   (w_stall_clr),
        .o_count (w_stall_cnt)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wait_max <= '0;
        end else if (w_stall_clr && (w_stall_cnt > r_wait_max)) begin
            r_wait_max <= w_stall_cnt;
        end
    end

    assign host_wait_max = r_wait_max;

endmodule
